// File: rtl/hm_scan_if.sv
// Port bundle between the host-memory page scanner and its host side.
// Control inputs (start/abort/mem_busy) are level signals sampled on sys_clk;
// there is no valid/ready handshake: the scanner owns the buffer's port-A
// address every cycle, and read data is valid one cycle after the address
// unless mem_busy stole that cycle.
interface hm_scan_if;
    logic        start;
    logic        abort;
    logic        mem_busy;
    logic [63:0] pattern;
    logic [63:0] mask;
    logic [63:0] hm_addr;
    logic [63:0] hm_data;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic [63:0] checksum;
    logic [9:0]  match_cnt;
    logic [8:0]  first_idx;
    logic        found;
    logic [1:0]  scan_state;

    modport master (
        output start, abort, mem_busy, pattern, mask, hm_data,
        input  hm_addr, busy, done, result_valid, checksum, match_cnt,
               first_idx, found, scan_state
    );

    modport slave (
        input  start, abort, mem_busy, pattern, mask, hm_data,
        output hm_addr, busy, done, result_valid, checksum, match_cnt,
               first_idx, found, scan_state
    );
endinterface

// File: rtl/hm_scan.sv
// Host-memory page scanner: walks the completion buffer one qword per cycle,
// folding each qword into a rotate-XOR checksum and counting qwords that
// match a masked pattern. scan_state exposes the FSM for debug.
module hm_scan #(
    parameter int QWORDS = 512
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    hm_scan_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [9:0] LAST_IDX = 10'(QWORDS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  issue_idx;
    logic        rd_v;
    logic [8:0]  rd_idx;
    logic [63:0] pat_q;
    logic [63:0] mask_q;
    logic        start_acc;
    logic        hit;

    // abort wins over a simultaneous start, so the start is simply not taken
    assign start_acc = (state == IDLE) && bus.start && !bus.abort;
    assign hit       = ((bus.hm_data ^ pat_q) & mask_q) == 64'd0;

    assign bus.hm_addr    = {52'd0, issue_idx[8:0], 3'b000};
    assign bus.busy       = (state == SCAN) || (state == DRAIN);
    assign bus.done       = (state == DONE);
    assign bus.scan_state = state;

    // State register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic; abort overrides every non-IDLE transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_acc) state_nxt = SCAN;
            SCAN:  if (!bus.mem_busy && issue_idx == LAST_IDX) state_nxt = DRAIN;
            DRAIN: if (rd_v) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort && state != IDLE) state_nxt = IDLE;
    end

    // Issue counter: advances on honoured SCAN cycles, parked at 0 otherwise
    // so the address bus shows index 0 whenever the scanner is not scanning.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            issue_idx <= 10'd0;
        end else if (state_nxt != SCAN) begin
            issue_idx <= 10'd0;
        end else if (state == SCAN && !bus.mem_busy) begin
            issue_idx <= issue_idx + 10'd1;
        end
    end

    // Read-data valid pipeline: data for rd_idx arrives one cycle after issue
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rd_v   <= 1'b0;
            rd_idx <= 9'd0;
        end else begin
            rd_v   <= (state == SCAN) && !bus.mem_busy && !bus.abort;
            rd_idx <= issue_idx[8:0];
        end
    end

    // Accumulators: cleared and compare value latched on an accepted start
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bus.checksum  <= 64'd0;
            bus.match_cnt <= 10'd0;
            bus.first_idx <= 9'd0;
            bus.found     <= 1'b0;
            pat_q         <= 64'd0;
            mask_q        <= 64'd0;
        end else if (start_acc) begin
            bus.checksum  <= 64'd0;
            bus.match_cnt <= 10'd0;
            bus.first_idx <= 9'd0;
            bus.found     <= 1'b0;
            pat_q         <= bus.pattern;
            mask_q        <= bus.mask;
        end else if (rd_v) begin
            bus.checksum <= {bus.checksum[62:0], bus.checksum[63]} ^ bus.hm_data;
            if (hit) begin
                bus.match_cnt <= bus.match_cnt + 10'd1;
                if (!bus.found) begin
                    bus.found     <= 1'b1;
                    bus.first_idx <= rd_idx;
                end
            end
        end
    end

    // Result-valid flag: raised on entry to DONE, dropped by a new scan
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bus.result_valid <= 1'b0;
        end else if (start_acc) begin
            bus.result_valid <= 1'b0;
        end else if (state_nxt == DONE && state != DONE) begin
            bus.result_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hm_scan.sv
// Randomised self-checking bench for hm_scan against a page-level model.
module tb_hm_scan;

    localparam int QW = 512;

    logic sys_clk;
    logic sys_rst_n;
    hm_scan_if bus();

    hm_scan #(.QWORDS(QW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    // ---------------- clock / reset ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- buffer model ----------------
    logic [63:0] mem [0:QW-1];
    always @(posedge sys_clk) bus.hm_data <= mem[bus.hm_addr[11:3]];

    bit busy_sched [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    int          r_done_cyc;
    int          r_n_done;
    logic        r_busy_c1;
    logic        r_busy_after_abort;
    logic        r_rst_or;

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotl(input logic [63:0] w, input int s);
        logic [127:0] t;
        t = {w, w} << s;
        return t[127:64];
    endfunction

    // Page-level reference: qword i ends up rotated left by (QW-1-i) mod 64
    task automatic model(input logic [63:0] pat, input logic [63:0] msk,
                         output logic [63:0] cks, output int cnt,
                         output int fidx, output bit fnd);
        int idxs[$];
        cks = 64'd0;
        for (int i = 0; i < QW; i++) begin
            cks ^= rotl(mem[i], (QW - 1 - i) % 64);
            if ((mem[i] & msk) == (pat & msk)) idxs.push_back(i);
        end
        cnt  = idxs.size();
        fnd  = (cnt != 0);
        fidx = fnd ? idxs[0] : 0;
    endtask

    task automatic check_results(input string pfx, input logic [63:0] pat, input logic [63:0] msk);
        logic [63:0] cks;
        int cnt, fidx;
        bit fnd;
        model(pat, msk, cks, cnt, fidx, fnd);
        check({pfx, "_cks"},   bus.checksum, cks);
        check({pfx, "_cnt"},   64'(bus.match_cnt), 64'(cnt));
        check({pfx, "_first"}, 64'(bus.first_idx), 64'(fidx));
        check({pfx, "_found"}, 64'(bus.found), 64'(fnd));
    endtask

    function automatic int sched_count();
        int n = 0;
        for (int i = 0; i < 1024; i++) if (busy_sched[i]) n++;
        return n;
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < 1024; i++) busy_sched[i] = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Called at #1 after a rising edge. Cycle c is the period after edge c-1
    // of the start edge (E0).
    task automatic run_scan(input logic [63:0] pat, input logic [63:0] msk,
                            input int abort_cyc, input int rst_cyc,
                            input int extra_cyc, input bit start_on_done);
        r_done_cyc         = -1;
        r_n_done           = 0;
        r_busy_c1          = 1'b0;
        r_busy_after_abort = 1'b1;
        r_rst_or           = 1'b1;
        bus.pattern = pat;
        bus.mask    = msk;
        bus.start   = 1'b1;
        @(posedge sys_clk); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= QW + 40; cyc++) begin
            bus.mem_busy = busy_sched[cyc];
            bus.abort    = (cyc == abort_cyc);
            sys_rst_n    = (cyc != rst_cyc);
            bus.start    = (cyc == extra_cyc) || (start_on_done && bus.done);
            if (bus.start) begin
                bus.pattern = ~pat;
                bus.mask    = '1;
            end
            if (cyc == 1) r_busy_c1 = bus.busy;
            if (bus.done) begin
                r_n_done++;
                r_done_cyc = cyc;
            end
            if (cyc == abort_cyc + 1) r_busy_after_abort = bus.busy;
            if (cyc == rst_cyc + 1)
                r_rst_or = |{bus.busy, bus.done, bus.result_valid, bus.found,
                             bus.checksum, bus.match_cnt, bus.first_idx, bus.hm_addr};
            @(posedge sys_clk); #1;
        end
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.mem_busy = 1'b0;
        sys_rst_n    = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] pat, msk, cks0;
        int exp_done;

        bus.start = 0; bus.abort = 0; bus.mem_busy = 0;
        bus.pattern = 0; bus.mask = 0;
        for (int i = 0; i < QW; i++) mem[i] = 64'd0;
        clear_sched();
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_busy",  64'(bus.busy), 64'd0);
        check("rst_done",  64'(bus.done), 64'd0);
        check("rst_rv",    64'(bus.result_valid), 64'd0);
        check("rst_cks",   bus.checksum, 64'd0);
        check("rst_cnt",   64'(bus.match_cnt), 64'd0);
        check("rst_first", 64'(bus.first_idx), 64'd0);
        check("rst_found", 64'(bus.found), 64'd0);
        check("rst_addr",  bus.hm_addr, 64'd0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // all-zero buffer
        run_scan(64'd0, 64'd0, -10, -10, -10, 1'b0);
        check("zero_done_cyc", 64'(r_done_cyc), 64'd514);
        check("zero_n_done",   64'(r_n_done), 64'd1);
        check("zero_busy_c1",  64'(r_busy_c1), 64'd1);
        check("zero_cks",      bus.checksum, 64'd0);
        check("zero_cnt",      64'(bus.match_cnt), 64'd512);
        check("zero_found",    64'(bus.found), 64'd1);
        check("zero_first",    64'(bus.first_idx), 64'd0);
        check("zero_rv",       64'(bus.result_valid), 64'd1);
        check("zero_idle",     64'(bus.busy), 64'd0);
        check("zero_addr",     bus.hm_addr, 64'd0);

        // rotation
        mem[0] = 64'd1;
        run_scan(64'd1, '1, -10, -10, -10, 1'b0);
        check("rot0_cks",   bus.checksum, 64'h8000_0000_0000_0000);
        check("rot0_cnt",   64'(bus.match_cnt), 64'd1);
        check("rot0_first", 64'(bus.first_idx), 64'd0);
        mem[0] = 64'd0;
        mem[QW-1] = 64'd1;
        run_scan(64'd1, '1, -10, -10, -10, 1'b0);
        check("rot511_cks",   bus.checksum, 64'd1);
        check("rot511_first", 64'(bus.first_idx), 64'd511);
        check_results("rot511", 64'd1, '1);

        // contention
        for (int i = 0; i < QW; i++) mem[i] = 64'(i);
        run_scan(64'h0123, 64'hFFFF, -10, -10, -10, 1'b0);
        cks0 = bus.checksum;
        check_results("ramp", 64'h0123, 64'hFFFF);
        busy_sched[10] = 1; busy_sched[11] = 1; busy_sched[12] = 1; busy_sched[300] = 1;
        run_scan(64'h0123, 64'hFFFF, -10, -10, -10, 1'b0);
        check("cont_done_cyc", 64'(r_done_cyc), 64'd518);
        check("cont_cks_same", bus.checksum, cks0);
        check("cont_cnt",      64'(bus.match_cnt), 64'd1);
        check("cont_first",    64'(bus.first_idx), 64'h123);
        check_results("cont", 64'h0123, 64'hFFFF);
        clear_sched();

        // abort then full scan
        for (int i = 0; i < QW; i++) mem[i] = {$urandom, $urandom};
        run_scan(64'd5, 64'd7, 100, -10, -10, 1'b0);
        check("abort_n_done", 64'(r_n_done), 64'd0);
        check("abort_busy",   64'(r_busy_after_abort), 64'd0);
        check("abort_rv",     64'(bus.result_valid), 64'd0);
        check("abort_idle",   64'(bus.busy), 64'd0);
        run_scan(64'd5, 64'd7, -10, -10, -10, 1'b0);
        check("post_abort_done_cyc", 64'(r_done_cyc), 64'd514);
        check("post_abort_rv",       64'(bus.result_valid), 64'd1);
        check_results("post_abort", 64'd5, 64'd7);

        // ignored starts at cycle 50 and in the DONE cycle
        run_scan(64'd2, 64'd3, -10, -10, 50, 1'b1);
        check("ign_n_done",   64'(r_n_done), 64'd1);
        check("ign_done_cyc", 64'(r_done_cyc), 64'd514);
        check("ign_rv",       64'(bus.result_valid), 64'd1);
        check("ign_idle",     64'(bus.busy), 64'd0);
        check_results("ign", 64'd2, 64'd3);

        // start and abort together in IDLE: not taken, results kept
        bus.start = 1; bus.abort = 1; bus.pattern = 64'd1; bus.mask = 64'd1;
        @(posedge sys_clk); #1;
        bus.start = 0; bus.abort = 0;
        check("sa_busy", 64'(bus.busy), 64'd0);
        check("sa_rv",   64'(bus.result_valid), 64'd1);
        repeat (3) @(posedge sys_clk);
        #1;
        check("sa_busy_later", 64'(bus.busy), 64'd0);
        check_results("sa_kept", 64'd2, 64'd3);

        // reset mid-scan
        run_scan(64'd0, 64'd0, -10, 200, -10, 1'b0);
        check("mrst_n_done", 64'(r_n_done), 64'd0);
        check("mrst_zero",   64'(r_rst_or), 64'd0);
        check("mrst_rv",     64'(bus.result_valid), 64'd0);

        // randomised scans with random contention
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < QW; i++)
                mem[i] = {$urandom, $urandom} ^ 64'($urandom_range(0, 3));
            pat = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       msk = 64'd3;
                1:       msk = 64'd0;
                default: msk = 64'd1 << $urandom_range(0, 63);
            endcase
            clear_sched();
            for (int k = 0; k < int'($urandom_range(0, 6)); k++)
                busy_sched[$urandom_range(1, 400)] = 1'b1;
            exp_done = QW + 2 + sched_count();
            run_scan(pat, msk, -10, -10, -10, 1'b0);
            check("rnd_done_cyc", 64'(r_done_cyc), 64'(exp_done));
            check("rnd_n_done",   64'(r_n_done), 64'd1);
            check_results("rnd", pat, msk);
        end
        clear_sched();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
